// File: rtl/btn_inport.sv
// btn_inport: synchronized, debounced input port with sticky edge flags,
// a four-register CPU window and a registered interrupt request.
module btn_inport #(
  parameter int WIDTH    = 32,
  parameter int DB_TICKS = 4,
  parameter int DIV      = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_in,
  input  logic             cs,
  input  logic             wen,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq
);
  logic [WIDTH-1:0] sync1_q, sync2_q, stable_q, stable_d, rise_q, rise_d, fall_q, fall_d, ie_q, ie_d;
  logic [3:0]       dc_q [WIDTH];
  logic [3:0]       dc_d [WIDTH];
  logic [15:0]      cnt_q, cnt_d;
  logic             irq_q, irq_d, tick, wr;
  assign tick  = cnt_q == 16'(DIV - 1);
  assign wr    = cs & wen;
  assign cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
  always_comb begin
    stable_d = stable_q;
    dc_d     = dc_q;
    for (int i = 0; i < WIDTH; i++) begin
      stable_d[i] = tick && sync2_q[i] != stable_q[i] && dc_q[i] == 4'(DB_TICKS - 1) ? sync2_q[i] : stable_q[i];
      dc_d[i]     = !tick ? dc_q[i]
                  : (sync2_q[i] == stable_q[i] || dc_q[i] == 4'(DB_TICKS - 1)) ? 4'd0 : dc_q[i] + 4'd1;
    end
  end
  // A newly accepted edge wins over a same-cycle write-1-to-clear
  assign rise_d = (rise_q & ~(wr && addr == 2'd1 ? wdata[WIDTH-1:0] : '0)) | (stable_d & ~stable_q);
  assign fall_d = (fall_q & ~(wr && addr == 2'd2 ? wdata[WIDTH-1:0] : '0)) | (~stable_d & stable_q);
  assign ie_d   = wr && addr == 2'd3 ? wdata[WIDTH-1:0] : ie_q;
  assign irq_d  = |((rise_q | fall_q) & ie_q);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      dc_q     <= '{default: '0};
      cnt_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      ie_q     <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync1_q  <= pin_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      dc_q     <= dc_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      ie_q     <= ie_d;
      irq_q    <= irq_d;
    end
  end
  assign rdata = !cs ? 32'd0
               : addr == 2'd0 ? 32'(stable_q)
               : addr == 2'd1 ? 32'(rise_q)
               : addr == 2'd2 ? 32'(fall_q) : 32'(ie_q);
  assign irq = irq_q;
endmodule

// File: tb/tb_btn_inport.sv
// tb_btn_inport: scoreboard bench for btn_inport against a sliding-window
// debounce reference model, with directed scenarios and a random phase.
module tb_btn_inport;
  localparam int DB = 4, DIV = 10;
  logic        clk = 0, reset = 1, cs = 0, wen = 0, irq;
  logic [31:0] pin_in = 0, wdata = 0, rdata, pins = 0;
  logic [1:0]  addr = 0;
  int          errors = 0, checks = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  btn_inport dut (.clk(clk), .reset(reset), .pin_in(pin_in), .cs(cs), .wen(wen),
                  .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq));

  // Reference: a level is accepted when the last DB tick samples all oppose it
  logic [31:0] m_s1, m_s2, m_stable, m_rise, m_fall, m_ie, a_all, o_all, m_up, m_dn, clr_r, clr_f;
  logic [31:0] hist [DB-1];
  logic        m_irq, m_tick;
  int          m_cnt;
  always_comb begin
    m_tick = m_cnt == DIV - 1;
    a_all  = m_s2;
    o_all  = m_s2;
    for (int k = 0; k < DB - 1; k++) begin
      a_all = a_all & hist[k];
      o_all = o_all | hist[k];
    end
    m_up  = m_tick ? a_all & ~m_stable : 32'd0;
    m_dn  = m_tick ? ~o_all & m_stable : 32'd0;
    clr_r = (cs && wen && addr == 2'd1) ? wdata : 32'd0;
    clr_f = (cs && wen && addr == 2'd2) ? wdata : 32'd0;
  end
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 <= 0; m_s2 <= 0; m_stable <= 0; m_rise <= 0; m_fall <= 0; m_ie <= 0;
      m_irq <= 0; m_cnt <= 0;
      for (int k = 0; k < DB - 1; k++) hist[k] <= 0;
    end else begin
      m_s1     <= pin_in;
      m_s2     <= m_s1;
      m_cnt    <= m_tick ? 0 : m_cnt + 1;
      m_stable <= m_stable ^ m_up ^ m_dn;
      m_rise   <= (m_rise & ~clr_r) | m_up;
      m_fall   <= (m_fall & ~clr_f) | m_dn;
      m_ie     <= (cs && wen && addr == 2'd3) ? wdata : m_ie;
      m_irq    <= |((m_rise | m_fall) & m_ie);
      if (m_tick) begin
        hist[0] <= m_s2;
        for (int k = 1; k < DB - 1; k++) hist[k] <= hist[k-1];
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    if (!reset) return 32'd0;
    return a == 2'd0 ? m_stable : a == 2'd1 ? m_rise : a == 2'd2 ? m_fall : m_ie;
  endfunction

  always @(negedge clk) begin
    logic [31:0] e;
    checks++;
    if (irq !== m_irq) begin
      errors++;
      $display("FAIL irq_model: got %b expected %b at %0t", irq, m_irq, $time);
    end
    if (cs && !wen) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: read with no expectation at %0t", $time);
      end else begin
        e = sb.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL read_addr%0d: got %h expected %h at %0t", addr, rdata, e, $time);
        end
      end
    end else if (!cs) begin
      checks++;
      if (rdata !== 32'd0) begin
        errors++;
        $display("FAIL rdata_nocs: got %h expected 0 at %0t", rdata, $time);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  task automatic rng_chk(input string nm, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, v, lo, hi);
    end
  endtask

  task automatic step(input logic c, input logic w, input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    pin_in = pins; cs = c; wen = w; addr = a; wdata = d;
    if (c && !w) sb.push_back(exp_rd(a));
  endtask

  task automatic idle(input int n);
    repeat (n) step($urandom_range(0, 7) != 0, 1'b0, 2'($urandom_range(0, 3)), 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] e, input string nm);
    step(1'b1, 1'b0, a, 32'd0);
    @(negedge clk);
    chk(nm, rdata, e);
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk);
    #1;
    reset = 0; pin_in = pins; cs = 1; wen = 0; addr = 2'($urandom_range(0, 3));
    sb.push_back(32'd0);
    @(negedge clk);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    idle(hold);
    @(posedge clk);
    #1;
    reset = 1; cs = 1; wen = 0; addr = 2'($urandom_range(0, 3));
    sb.push_back(exp_rd(addr));
  endtask

  // lat counts edges after the edge that first samples the new pin level
  task automatic wait_state(input logic [31:0] want, output int lat);
    lat = -1;
    for (int k = 1; k <= 70; k++) begin
      step(1'b1, 1'b0, 2'd0, 32'd0);
      @(negedge clk);
      if (rdata == want) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, r;
    #2 reset = 0;
    do_reset(3);
    idle(9);
    rd_chk(2'd0, 32'd0, "init_state");
    rd_chk(2'd1, 32'd0, "init_rise");
    rd_chk(2'd2, 32'd0, "init_fall");
    rd_chk(2'd3, 32'd0, "init_ie");
    chk("init_irq", 32'(irq), 32'd0);

    wr(2'd3, 32'h4);
    pins = 32'h4;
    step(1'b1, 1'b0, 2'd0, 32'd0);
    wait_state(32'h4, lat);
    rng_chk("press_latency", lat, 32, 41);
    rd_chk(2'd1, 32'h4, "press_rise");
    chk("press_irq", 32'(irq), 32'd1);
    pins = 0;
    idle(60);
    wr(2'd1, 32'h4);
    wr(2'd2, 32'h4);
    idle(2);
    @(negedge clk);
    chk("cleared_irq", 32'(irq), 32'd0);

    pins = 32'h4;
    idle(25);
    pins = 0;
    idle(80);
    rd_chk(2'd0, 32'd0, "glitch_state");
    rd_chk(2'd1, 32'd0, "glitch_rise");
    rd_chk(2'd2, 32'd0, "glitch_fall");
    chk("glitch_irq", 32'(irq), 32'd0);

    pins = 32'h4;
    idle(100);
    pins = 0;
    idle(100);
    rd_chk(2'd1, 32'h4, "pr_rise");
    rd_chk(2'd2, 32'h4, "pr_fall");
    wr(2'd1, 32'h4);
    rd_chk(2'd1, 32'd0, "w1c_rise");
    rd_chk(2'd2, 32'h4, "w1c_fall_kept");
    chk("irq_kept", 32'(irq), 32'd1);
    wr(2'd2, 32'h4);
    rd_chk(2'd2, 32'd0, "w1c_fall");
    chk("irq_hold", 32'(irq), 32'd1);
    idle(1);
    @(negedge clk);
    chk("irq_drop", 32'(irq), 32'd0);

    // Pin held high across reset: acceptance lands on the 40th edge after release
    pins = 32'h4;
    do_reset(2);
    idle(38);
    wr(2'd1, 32'h4);
    rd_chk(2'd1, 32'h4, "collision_rise");
    rd_chk(2'd0, 32'h4, "collision_state");

    pins = 0;
    idle(60);
    pins = 32'h4;
    idle(20);
    do_reset(2);
    wait_state(32'h4, lat);
    rng_chk("reset_latency", lat, 32, 41);

    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 999);
      if (r < 3) do_reset($urandom_range(1, 4));
      else if (r < 60) wr(2'($urandom_range(0, 3)), $urandom);
      else begin
        if (r < 100) pins = pins ^ (32'd1 << $urandom_range(0, r[0] ? 3 : 31));
        idle(1);
      end
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
